vga_timing_monitor: RTL and testbench

VGA_TIMING_MONITOR -- requirements
Module: vga_timing_monitor

---
 rtl/vga_timing_pkg.sv | 28 ++
 rtl/vga_sync_edge_det.sv | 28 ++
 rtl/vga_timing_monitor.sv | 212 +++++++++++++++++++++
 tb/tb_vga_timing_monitor.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - VGA 640x480 timing constants and monitor state type
// Shared by the VGA timing stage and vga_timing_monitor.
//   HACT/HFP/HSW/HBP : horizontal active, front porch, sync width, back porch (pixels)
//   VACT/VFP/VSW/VBP : vertical active, front porch, sync width, back porch (lines)
//   mon_state_e      : monitor FSM states
//   sat_inc10        : 10-bit saturating increment used by the monitor counters
package vga_timing_pkg;

  localparam int HACT = 640;
  localparam int HFP  = 16;
  localparam int HSW  = 96;
  localparam int HBP  = 48;
  localparam int VACT = 480;
  localparam int VFP  = 10;
  localparam int VSW  = 2;
  localparam int VBP  = 33;

  typedef enum logic [1:0] {
    MON_IDLE    = 2'd0,
    MON_MEASURE = 2'd1,
    MON_LOCKED  = 2'd2
  } mon_state_e;

  function automatic logic [9:0] sat_inc10(input logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/vga_sync_edge_det.sv
// rtl/vga_sync_edge_det.sv - fall/rise detector for one active-low sync line
// Ports:
//   clk_i   : pixel clock
//   rst_i   : asynchronous active-high reset
//   sync_i  : sync input sample
//   fall_o  : high in the cycle sync_i is 0 and the previous sample was 1
//   rise_o  : high in the cycle sync_i is 1 and the previous sample was 0
module vga_sync_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sync_i,
  output logic fall_o,
  output logic rise_o
);

  logic prev_q;

  // Previous sample resets to the idle (high) level so a released reset
  // with the sync line high produces no edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) prev_q <= 1'b1;
    else       prev_q <= sync_i;
  end

  assign fall_o = ~sync_i & prev_q;
  assign rise_o = sync_i & ~prev_q;

endmodule

// File: rtl/vga_timing_monitor.sv
// rtl/vga_timing_monitor.sv - measures VGA line/frame timing and flags mismatches
// Optional feature macro: VGA_MON_CHECKSUM_EN (per-frame sum of red_in over valid cycles).
// Ports:
//   pix_clk, reset        : pixel clock, asynchronous active-high reset
//   hsync_in, vsync_in    : active-low syncs from the timing stage
//   red_in, valid_in      : pixel data and active-pixel qualifier
//   clr_errors            : synchronous clear of the sticky error flags
//   locked                : high while the FSM is LOCKED
//   frame_done            : one-cycle pulse after a frame closes
//   line_px_count         : pixel count of the last closed active line
//   frame_line_count      : active-line count of the last closed frame
//   frame_count           : closed frames since reset (wraps)
//   err_hact/vact/hsw/vsw : sticky mismatch flags (set only while LOCKED)
//   frame_checksum        : red_in sum of the last frame, 0 without the macro
module vga_timing_monitor
  import vga_timing_pkg::*;
#(
  parameter int HACT = vga_timing_pkg::HACT,
  parameter int VACT = vga_timing_pkg::VACT,
  parameter int HSW  = vga_timing_pkg::HSW,
  parameter int VSW  = vga_timing_pkg::VSW
) (
  input  logic        pix_clk,
  input  logic        reset,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [7:0]  red_in,
  input  logic        valid_in,
  input  logic        clr_errors,
  output logic        locked,
  output logic        frame_done,
  output logic [9:0]  line_px_count,
  output logic [9:0]  frame_line_count,
  output logic [15:0] frame_count,
  output logic        err_hact,
  output logic        err_vact,
  output logic        err_hsw,
  output logic        err_vsw,
  output logic [15:0] frame_checksum
);

  localparam logic [9:0] HACT_W = 10'(HACT);
  localparam logic [9:0] VACT_W = 10'(VACT);
  localparam logic [9:0] HSW_W  = 10'(HSW);
  localparam logic [9:0] VSW_W  = 10'(VSW);

  logic h_fall, h_rise, v_fall, v_rise;

  vga_sync_edge_det u_hsync_edge (
    .clk_i(pix_clk), .rst_i(reset), .sync_i(hsync_in), .fall_o(h_fall), .rise_o(h_rise)
  );

  vga_sync_edge_det u_vsync_edge (
    .clk_i(pix_clk), .rst_i(reset), .sync_i(vsync_in), .fall_o(v_fall), .rise_o(v_rise)
  );

  mon_state_e  state_q, state_d;
  logic [9:0]  px_cnt_q, px_cnt_d;
  logic [9:0]  line_cnt_q, line_cnt_d;
  logic [9:0]  hlow_cnt_q, hlow_cnt_d;
  logic [9:0]  vlow_cnt_q, vlow_cnt_d;
  logic        frame_bad_q, frame_bad_d;
  logic        locked_q, locked_d;
  logic        frame_done_q, frame_done_d;
  logic [9:0]  line_px_q, line_px_d;
  logic [9:0]  frame_line_q, frame_line_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [3:0]  err_q, err_d;  // {hact, vact, hsw, vsw}

  logic       line_close, hact_bad, hsw_bad, vsw_bad, vact_bad, any_bad;
  logic [9:0] lines_closed;

  always_comb begin
    state_d      = state_q;
    px_cnt_d     = px_cnt_q;
    line_cnt_d   = line_cnt_q;
    hlow_cnt_d   = hlow_cnt_q;
    vlow_cnt_d   = vlow_cnt_q;
    frame_bad_d  = frame_bad_q;
    frame_done_d = 1'b0;
    line_px_d    = line_px_q;
    frame_line_d = frame_line_q;
    frame_cnt_d  = frame_cnt_q;
    err_d        = err_q;

    line_close = h_fall && (px_cnt_q != 10'd0);
    hact_bad   = line_close && (px_cnt_q != HACT_W);
    hsw_bad    = h_rise && (hlow_cnt_q != HSW_W);
    vsw_bad    = v_rise && (vlow_cnt_q != VSW_W);
    // A line closing in the same cycle as the vsync fall belongs to the closing frame.
    lines_closed = line_close ? sat_inc10(line_cnt_q) : line_cnt_q;
    vact_bad   = v_fall && (lines_closed != VACT_W);
    any_bad    = hact_bad || hsw_bad || vsw_bad;

    if (h_fall)        px_cnt_d = 10'd0;
    else if (valid_in) px_cnt_d = sat_inc10(px_cnt_q);

    if (line_close) begin
      line_px_d  = px_cnt_q;
      line_cnt_d = sat_inc10(line_cnt_q);
    end

    // The fall cycle itself is the first low cycle.
    if (h_fall)         hlow_cnt_d = 10'd1;
    else if (!hsync_in) hlow_cnt_d = sat_inc10(hlow_cnt_q);

    if (v_fall)                    vlow_cnt_d = h_fall ? 10'd1 : 10'd0;
    else if (h_fall && !vsync_in)  vlow_cnt_d = sat_inc10(vlow_cnt_q);

    frame_bad_d = frame_bad_q || any_bad;

    // Clear first so that an error detected in the same cycle wins.
    if (clr_errors) err_d = 4'b0000;
    if (state_q == MON_LOCKED) begin
      if (hact_bad) err_d[3] = 1'b1;
      if (vact_bad) err_d[2] = 1'b1;
      if (hsw_bad)  err_d[1] = 1'b1;
      if (vsw_bad)  err_d[0] = 1'b1;
    end

    if (v_fall) begin
      frame_line_d = lines_closed;
      line_cnt_d   = 10'd0;
      frame_bad_d  = 1'b0;
      if (state_q != MON_IDLE) begin
        frame_cnt_d  = frame_cnt_q + 16'd1;
        frame_done_d = 1'b1;
      end
    end

    case (state_q)
      MON_IDLE:    if (v_fall) state_d = MON_MEASURE;
      MON_MEASURE: if (v_fall && !vact_bad && !frame_bad_q && !any_bad) state_d = MON_LOCKED;
      MON_LOCKED:  if (any_bad || vact_bad) state_d = MON_MEASURE;
      default:     state_d = MON_IDLE;
    endcase

    locked_d = (state_d == MON_LOCKED);
  end

  always_ff @(posedge pix_clk or posedge reset) begin
    if (reset) begin
      state_q      <= MON_IDLE;
      px_cnt_q     <= '0;
      line_cnt_q   <= '0;
      hlow_cnt_q   <= '0;
      vlow_cnt_q   <= '0;
      frame_bad_q  <= 1'b0;
      locked_q     <= 1'b0;
      frame_done_q <= 1'b0;
      line_px_q    <= '0;
      frame_line_q <= '0;
      frame_cnt_q  <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      px_cnt_q     <= px_cnt_d;
      line_cnt_q   <= line_cnt_d;
      hlow_cnt_q   <= hlow_cnt_d;
      vlow_cnt_q   <= vlow_cnt_d;
      frame_bad_q  <= frame_bad_d;
      locked_q     <= locked_d;
      frame_done_q <= frame_done_d;
      line_px_q    <= line_px_d;
      frame_line_q <= frame_line_d;
      frame_cnt_q  <= frame_cnt_d;
      err_q        <= err_d;
    end
  end

`ifdef VGA_MON_CHECKSUM_EN
  logic [15:0] acc_q, acc_d, chk_q, chk_d;

  always_comb begin
    acc_d = acc_q;
    chk_d = chk_q;
    if (v_fall) begin
      chk_d = acc_q;
      acc_d = 16'd0;
    end else if (valid_in) begin
      acc_d = acc_q + 16'(red_in);
    end
  end

  always_ff @(posedge pix_clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      chk_q <= '0;
    end else begin
      acc_q <= acc_d;
      chk_q <= chk_d;
    end
  end

  assign frame_checksum = chk_q;
`else
  logic red_unused;
  assign red_unused     = ^red_in;
  assign frame_checksum = 16'd0;
`endif

  assign locked           = locked_q;
  assign frame_done       = frame_done_q;
  assign line_px_count    = line_px_q;
  assign frame_line_count = frame_line_q;
  assign frame_count      = frame_cnt_q;
  assign err_hact         = err_q[3];
  assign err_vact         = err_q[2];
  assign err_hsw          = err_q[1];
  assign err_vsw          = err_q[0];

endmodule

// File: tb/tb_vga_timing_monitor.sv
// tb/tb_vga_timing_monitor.sv - scoreboard bench for vga_timing_monitor
module tb_vga_timing_monitor;

  localparam int TH  = 64;
  localparam int TV  = 16;
  localparam int THS = 8;
  localparam int TVS = 2;

  logic        pix_clk = 1'b0;
  logic        reset;
  logic        hsync_in, vsync_in, valid_in, clr_errors;
  logic [7:0]  red_in;
  logic        locked, frame_done;
  logic [9:0]  line_px_count, frame_line_count;
  logic [15:0] frame_count, frame_checksum;
  logic        err_hact, err_vact, err_hsw, err_vsw;

  always #5 pix_clk = ~pix_clk;

  vga_timing_monitor #(.HACT(TH), .VACT(TV), .HSW(THS), .VSW(TVS)) dut (
    .pix_clk(pix_clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .red_in(red_in), .valid_in(valid_in), .clr_errors(clr_errors),
    .locked(locked), .frame_done(frame_done), .line_px_count(line_px_count),
    .frame_line_count(frame_line_count), .frame_count(frame_count),
    .err_hact(err_hact), .err_vact(err_vact), .err_hsw(err_hsw), .err_vsw(err_vsw),
    .frame_checksum(frame_checksum)
  );

  typedef struct {
    logic [9:0]  lines;
    logic [15:0] count;
    logic [9:0]  px;
    logic [15:0] sum;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;
  int   pushes = 0;
  int   pops = 0;
  logic fd_prev = 1'b0;

  // bench-side frame bookkeeping
  bit          in_idle = 1'b1;
  logic [15:0] exp_frames = 0;
  logic [9:0]  cur_lines = 0;
  logic [9:0]  last_px = 0;
  logic [15:0] cur_sum = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge pix_clk) begin
    if (fd_prev) chk("frame_done_one_cycle", {31'd0, frame_done}, 32'd0);
    if (frame_done) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL frame_done_unexpected: got pulse expected none");
      end else begin
        e = q.pop_front();
        pops++;
        chk("frame_line_count", {22'd0, frame_line_count}, {22'd0, e.lines});
        chk("frame_count", {16'd0, frame_count}, {16'd0, e.count});
        chk("line_px_count", {22'd0, line_px_count}, {22'd0, e.px});
        chk("frame_checksum", {16'd0, frame_checksum}, {16'd0, e.sum});
      end
    end
    fd_prev = frame_done;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge pix_clk);
    #1;
  endtask

  task automatic line(input int npx, input int hw, input logic vs, input logic clr,
                      input logic [7:0] r);
    hsync_in = 1'b0;
    vsync_in = vs;
    valid_in = 1'b0;
    repeat (hw) step();
    hsync_in = 1'b1;
    clr_errors = clr;
    step();
    clr_errors = 1'b0;
    step();
    valid_in = 1'b1;
    red_in = r;
    repeat (npx) step();
    valid_in = 1'b0;
    red_in = 8'd0;
    repeat (2) step();
  endtask

  // Vsync fall at the first line closes the previous frame, then two vsync lines and a blank line.
  task automatic vhead();
    exp_t x;
    if (!in_idle) begin
      x.lines = cur_lines;
      x.count = exp_frames + 16'd1;
      x.px    = last_px;
`ifdef VGA_MON_CHECKSUM_EN
      x.sum   = cur_sum;
`else
      x.sum   = 16'd0;
`endif
      q.push_back(x);
      pushes++;
      exp_frames = exp_frames + 16'd1;
    end
    in_idle = 1'b0;
    cur_lines = 0;
    cur_sum = 0;
    line(0, THS, 1'b0, 1'b0, 8'd0);
    line(0, THS, 1'b0, 1'b0, 8'd0);
    line(0, THS, 1'b1, 1'b0, 8'd0);
  endtask

  task automatic vbody(input int nact, input int bad_line, input int bad_px,
                       input int hsw_line, input int hsw_val, input logic clr,
                       input logic [7:0] r);
    int px, hw;
    for (int k = 0; k < nact; k++) begin
      px = (k == bad_line) ? bad_px : TH;
      hw = (k == hsw_line) ? hsw_val : THS;
      line(px, hw, 1'b1, clr && (k == hsw_line), r);
      cur_lines = cur_lines + 10'd1;
      last_px = 10'(px);
      cur_sum = cur_sum + 16'(px * int'(r));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_locked"}, {31'd0, locked}, 32'd0);
    chk({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
    chk({tag, "_frame_count"}, {16'd0, frame_count}, 32'd0);
    chk({tag, "_line_px"}, {22'd0, line_px_count}, 32'd0);
    chk({tag, "_frame_lines"}, {22'd0, frame_line_count}, 32'd0);
    chk({tag, "_errs"}, {28'd0, err_hact, err_vact, err_hsw, err_vsw}, 32'd0);
    chk({tag, "_checksum"}, {16'd0, frame_checksum}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    valid_in = 1'b0;
    red_in = 8'd0;
    clr_errors = 1'b0;
    repeat (3) step();
    chk_all_zero("reset");
    reset = 1'b0;
    repeat (4) step();

    // three compliant frames, lock after the second vsync fall
    vhead();
    vbody(TV, -1, 0, -1, 0, 1'b0, 8'hFF);
    vhead();
    chk("lock_after_2nd_fall", {31'd0, locked}, 32'd1);
    chk("count_after_2nd_fall", {16'd0, frame_count}, 32'd1);
    vbody(TV, -1, 0, -1, 0, 1'b0, 8'hFF);
    vhead();
    vbody(TV, -1, 0, -1, 0, 1'b0, 8'hFF);
    chk("locked_3_frames", {31'd0, locked}, 32'd1);
    chk("count_3_frames", {16'd0, frame_count}, 32'd2);
    chk("errs_3_frames", {28'd0, err_hact, err_vact, err_hsw, err_vsw}, 32'd0);

    // short line (HACT-1) in LOCKED; it is the last line so it closes with the vsync fall
    vhead();
    vbody(TV, TV - 1, TH - 1, -1, 0, 1'b0, 8'hFF);
    vhead();
    chk("hact_err", {31'd0, err_hact}, 32'd1);
    chk("hact_line_px", {22'd0, line_px_count}, TH - 1);
    chk("hact_unlocked", {31'd0, locked}, 32'd0);
    vbody(TV, -1, 0, -1, 0, 1'b0, 8'h01);

    // frame with VACT-1 lines in LOCKED
    vhead();
    chk("relock_before_vact", {31'd0, locked}, 32'd1);
    vbody(TV - 1, -1, 0, -1, 0, 1'b0, 8'h02);
    vhead();
    chk("vact_err", {31'd0, err_vact}, 32'd1);
    chk("vact_frame_lines", {22'd0, frame_line_count}, TV - 1);
    chk("vact_unlocked", {31'd0, locked}, 32'd0);
    vbody(TV, -1, 0, -1, 0, 1'b0, 8'h03);

    // clr_errors coincident with an hsync width of HSW-1
    vhead();
    chk("relock_before_hsw", {31'd0, locked}, 32'd1);
    vbody(TV, -1, 0, 3, THS - 1, 1'b1, 8'h04);
    chk("clr_vs_hsw_errs", {28'd0, err_hact, err_vact, err_hsw, err_vsw}, 32'b0010);
    chk("hsw_unlocked", {31'd0, locked}, 32'd0);

    // reset mid-line, then three clean frames
    vhead();
    chk("bad_frame_stays_measure", {31'd0, locked}, 32'd0);
    hsync_in = 1'b0;
    repeat (THS) step();
    hsync_in = 1'b1;
    repeat (2) step();
    valid_in = 1'b1;
    red_in = 8'h05;
    repeat (20) step();
    reset = 1'b1;
    #1;
    chk_all_zero("midreset");
    valid_in = 1'b0;
    red_in = 8'd0;
    repeat (3) step();
    reset = 1'b0;
    in_idle = 1'b1;
    exp_frames = 0;
    cur_lines = 0;
    cur_sum = 0;
    last_px = 0;
    repeat (5) step();
    chk_all_zero("release");

    vhead();
    vbody(TV, -1, 0, -1, 0, 1'b0, 8'h01);
    vhead();
    chk("relock_after_reset", {31'd0, locked}, 32'd1);
    vbody(TV, -1, 0, -1, 0, 1'b0, 8'h01);
    vhead();
    vbody(TV, -1, 0, -1, 0, 1'b0, 8'h01);
    vhead();
    repeat (4) step();
    chk("final_frame_count", {16'd0, frame_count}, 32'd3);
    chk("final_locked", {31'd0, locked}, 32'd1);
    chk("scoreboard_drained", q.size(), 32'd0);
    chk("scoreboard_pops", pops, pushes);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
